// File: rtl/bc_msg_pkg.sv
// Shared constants and helpers for the broadcast message arbiter.
package bc_msg_pkg;

  localparam int unsigned DEF_MSG_WIDTH     = 47;
  localparam int unsigned DEF_CORE_ID_WIDTH = 3;
  localparam int unsigned STAT_WIDTH        = 32;

  // Round-robin pointer after a grant to core gnt among n cores.
  function automatic int unsigned rr_next(input int unsigned gnt, input int unsigned n);
    return (gnt + 32'd1 >= n) ? 32'd0 : gnt + 32'd1;
  endfunction

endpackage

// File: rtl/bc_msg_fifo.sv
// Per-core message queue; power-of-two depth, flush clears contents in the same cycle.
module bc_msg_fifo
  import bc_msg_pkg::*;
#(
  parameter int unsigned MSG_WIDTH  = DEF_MSG_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [MSG_WIDTH-1:0] push_data,
  output logic [MSG_WIDTH-1:0] head,
  output logic [CW-1:0]        count
);

  logic [MSG_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [MSG_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bc_msg_arbiter.sv
// Round-robin collector rebroadcasting per-core messages on one shared bus.
// Optional per-core sent-message counters are built when BC_MSG_STATS_EN is defined.
module bc_msg_arbiter
  import bc_msg_pkg::*;
#(
  parameter int unsigned CORE_COUNT    = 8,
  parameter int unsigned CORE_ID_WIDTH = DEF_CORE_ID_WIDTH,
  parameter int unsigned MSG_WIDTH     = DEF_MSG_WIDTH,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CORE_COUNT-1:0]           core_reset,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_bc_msg,
  input  logic [CORE_COUNT-1:0]           s_bc_msg_valid,
  output logic [CORE_COUNT-1:0]           s_bc_msg_ready,
  output logic [MSG_WIDTH-1:0]            m_bc_msg,
  output logic                            m_bc_msg_valid,
  output logic [CORE_ID_WIDTH-1:0]        m_bc_msg_src,
  input  logic [CORE_ID_WIDTH-1:0]        stat_sel,
  output logic [STAT_WIDTH-1:0]           stat_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]            fifo_count [CORE_COUNT];
  logic [MSG_WIDTH-1:0]     fifo_head  [CORE_COUNT];
  logic [CORE_COUNT-1:0]    req, push, pop;
  logic                     gnt_vld;
  logic [CORE_ID_WIDTH-1:0] gnt_idx;
  int unsigned              srch_idx;
  logic [CORE_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [MSG_WIDTH-1:0]     m_msg_q, m_msg_d;
  logic [CORE_ID_WIDTH-1:0] m_src_q, m_src_d;
  logic                     m_vld_q, m_vld_d;

  for (genvar i = 0; i < int'(CORE_COUNT); i++) begin : g_core
    assign s_bc_msg_ready[i] = rst_n && !core_reset[i] && (fifo_count[i] != CW'(FIFO_DEPTH));
    assign push[i]           = s_bc_msg_valid[i] && s_bc_msg_ready[i];
    assign req[i]            = (fifo_count[i] != '0) && !core_reset[i];
    assign pop[i]            = gnt_vld && (gnt_idx == CORE_ID_WIDTH'(i));

    bc_msg_fifo #(
      .MSG_WIDTH  (MSG_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (core_reset[i]),
      .push      (push[i]),
      .pop       (pop[i]),
      .push_data (s_bc_msg[i*MSG_WIDTH +: MSG_WIDTH]),
      .head      (fifo_head[i]),
      .count     (fifo_count[i])
    );
  end

  // First requester at or after rr_ptr, wrapping modulo CORE_COUNT.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    srch_idx = '0;
    for (int unsigned k = 0; k < CORE_COUNT; k++) begin
      srch_idx = (32'(rr_ptr_q) + k) % CORE_COUNT;
      if (!gnt_vld && req[CORE_ID_WIDTH'(srch_idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = CORE_ID_WIDTH'(srch_idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    m_msg_d  = m_msg_q;
    m_src_d  = m_src_q;
    m_vld_d  = gnt_vld;
    if (gnt_vld) begin
      rr_ptr_d = CORE_ID_WIDTH'(rr_next(32'(gnt_idx), CORE_COUNT));
      m_msg_d  = fifo_head[gnt_idx];
      m_src_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      m_msg_q  <= '0;
      m_src_q  <= '0;
      m_vld_q  <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      m_msg_q  <= m_msg_d;
      m_src_q  <= m_src_d;
      m_vld_q  <= m_vld_d;
    end
  end

  assign m_bc_msg       = m_msg_q;
  assign m_bc_msg_src   = m_src_q;
  assign m_bc_msg_valid = m_vld_q;

`ifdef BC_MSG_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [CORE_COUNT];
  logic [STAT_WIDTH-1:0] stat_d [CORE_COUNT];
  logic [STAT_WIDTH-1:0] stat_count_q, stat_count_d;

  // Counters survive core_reset; only rst_n clears them.
  always_comb begin
    stat_d = stat_q;
    if (gnt_vld) stat_d[gnt_idx] = stat_q[gnt_idx] + STAT_WIDTH'(1);
    stat_count_d = stat_q[stat_sel];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q       <= '{default: '0};
      stat_count_q <= '0;
    end else begin
      stat_q       <= stat_d;
      stat_count_q <= stat_count_d;
    end
  end

  assign stat_count = stat_count_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Randomized and directed checks of bc_msg_arbiter against a queue-based reference model.
module tb_bc_msg_arbiter;
  import bc_msg_pkg::*;

  localparam int unsigned N     = 8;
  localparam int unsigned IDW   = 3;
  localparam int unsigned MW    = 47;
  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      core_reset;
  logic [N*MW-1:0]   s_bc_msg;
  logic [N-1:0]      s_bc_msg_valid;
  logic [N-1:0]      s_bc_msg_ready;
  logic [MW-1:0]     m_bc_msg;
  logic              m_bc_msg_valid;
  logic [IDW-1:0]    m_bc_msg_src;
  logic [IDW-1:0]    stat_sel;
  logic [31:0]       stat_count;

  always #5 clk = ~clk;

  bc_msg_arbiter #(
    .CORE_COUNT    (N),
    .CORE_ID_WIDTH (IDW),
    .MSG_WIDTH     (MW),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_reset     (core_reset),
    .s_bc_msg       (s_bc_msg),
    .s_bc_msg_valid (s_bc_msg_valid),
    .s_bc_msg_ready (s_bc_msg_ready),
    .m_bc_msg       (m_bc_msg),
    .m_bc_msg_valid (m_bc_msg_valid),
    .m_bc_msg_src   (m_bc_msg_src),
    .stat_sel       (stat_sel),
    .stat_count     (stat_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-core queues, round-robin pointer, expected output register.
  logic [MW-1:0]  mq   [N][$];
  logic [MW-1:0]  tx_q [N][$];
  bit             gate [N];
  int             rr;
  logic           ev;
  logic [MW-1:0]  em;
  logic [IDW-1:0] es;
  logic [31:0]    estat;
  logic [31:0]    scnt [N];
  logic [IDW-1:0] emit_src [$];
  logic [MW-1:0]  emit_msg [$];

  task automatic apply_inputs();
    for (int i = 0; i < int'(N); i++) begin
      s_bc_msg[i*MW +: MW] = (tx_q[i].size() != 0) ? tx_q[i][0] : MW'({$urandom, $urandom});
      s_bc_msg_valid[i]    = (tx_q[i].size() != 0) && gate[i];
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] acc;
    int g;
    apply_inputs();
    @(negedge clk);
    for (int i = 0; i < int'(N); i++)
      exp_rdy[i] = rst_n && !core_reset[i] && (mq[i].size() != DEPTH);
    check("ready", 64'(s_bc_msg_ready), 64'(exp_rdy));
    acc = s_bc_msg_valid & exp_rdy;
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        mq[i].delete();
        scnt[i] = '0;
      end
      rr = 0; ev = 1'b0; em = '0; es = '0; estat = '0;
    end else begin
`ifdef BC_MSG_STATS_EN
      estat = scnt[stat_sel];
`else
      estat = '0;
`endif
      g = -1;
      for (int k = 0; k < int'(N); k++) begin
        int idx;
        idx = (rr + k) % int'(N);
        if (g < 0 && mq[idx].size() != 0 && !core_reset[idx]) g = idx;
      end
      if (g >= 0) begin
        em = mq[g].pop_front();
        es = IDW'(g);
        ev = 1'b1;
        rr = (g + 1) % int'(N);
        scnt[g] = scnt[g] + 32'd1;
      end else begin
        ev = 1'b0;
      end
      for (int i = 0; i < int'(N); i++)
        if (core_reset[i]) mq[i].delete();
      for (int i = 0; i < int'(N); i++)
        if (acc[i]) mq[i].push_back(tx_q[i][0]);
    end
    for (int i = 0; i < int'(N); i++)
      if (acc[i]) void'(tx_q[i].pop_front());
    @(posedge clk);
    #1;
    check("valid", 64'(m_bc_msg_valid), 64'(ev));
    check("msg", 64'(m_bc_msg), 64'(em));
    check("src", 64'(m_bc_msg_src), 64'(es));
    check("stat", 64'(stat_count), 64'(estat));
    if (m_bc_msg_valid) begin
      emit_src.push_back(m_bc_msg_src);
      emit_msg.push_back(m_bc_msg);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < int'(N); i++)
      if (tx_q[i].size() != 0 || mq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain();
    int cyc;
    cyc = 0;
    while (pending() && cyc < 300) begin
      step();
      cyc++;
    end
    check("drain_bound", 64'(cyc >= 300), 64'(0));
  endtask

  initial begin
    logic [MW-1:0] last2;
    logic [31:0]   stat_exp;
    rst_n      = 1'b0;
    core_reset = '0;
    stat_sel   = '0;
    rr = 0; ev = 1'b0; em = '0; es = '0; estat = '0;
    for (int i = 0; i < int'(N); i++) begin
      gate[i] = 1'b1;
      scnt[i] = '0;
    end
    step();
    step();
    check("rst_valid", 64'(m_bc_msg_valid), 64'(0));
    check("rst_ready", 64'(s_bc_msg_ready), 64'(0));
    rst_n = 1'b1;

    // All cores present one message in the same cycle with rr_ptr at 0.
    emit_src.delete();
    for (int i = 0; i < int'(N); i++) tx_q[i].push_back(MW'(64'h100 + 64'(i)));
    drain();
    check("t2_count", 64'(emit_src.size()), 64'(8));
    for (int i = 0; i < emit_src.size(); i++)
      check($sformatf("t2_order%0d", i), 64'(emit_src[i]), 64'(i));

    // Lone message from core 3: two-cycle latency, single-cycle pulse.
    tx_q[3].push_back(MW'(64'h1234));
    step();
    check("t1_early", 64'(m_bc_msg_valid), 64'(0));
    step();
    check("t1_valid", 64'(m_bc_msg_valid), 64'(1));
    check("t1_msg", 64'(m_bc_msg), 64'h1234);
    check("t1_src", 64'(m_bc_msg_src), 64'(3));
    step();
    check("t1_pulse", 64'(m_bc_msg_valid), 64'(0));

    // Core 5 streams six messages against one each from cores 0..4.
    emit_msg.delete();
    for (int i = 0; i < 5; i++) tx_q[i].push_back(MW'(64'h5000 + 64'(i)));
    for (int k = 0; k < 6; k++) tx_q[5].push_back(MW'(64'h5500 + 64'(k)));
    drain();
    check("t3_count", 64'(emit_msg.size()), 64'(11));

    // core_reset pulse on core 2 with messages queued.
    emit_msg.delete();
    emit_src.delete();
    for (int k = 0; k < 4; k++) begin
      tx_q[0].push_back(MW'(64'h6000 + 64'(k)));
      tx_q[1].push_back(MW'(64'h6100 + 64'(k)));
    end
    for (int k = 0; k < 3; k++) tx_q[2].push_back(MW'(64'h6200 + 64'(k)));
    step();
    step();
    core_reset[2] = 1'b1;
    step();
    core_reset[2] = 1'b0;
    tx_q[2].push_back(MW'(64'h62AA));
    drain();
    last2 = '0;
    for (int i = 0; i < emit_src.size(); i++)
      if (emit_src[i] == IDW'(2)) last2 = emit_msg[i];
    check("t4_new", 64'(last2), 64'h62AA);

    // rst_n mid-operation with a message in the output register.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++) tx_q[i].push_back(MW'(64'h7000 + 64'(i * 16 + k)));
    step();
    step();
    step();
    rst_n = 1'b0;
    for (int i = 0; i < int'(N); i++) tx_q[i].delete();
    step();
    check("t5_valid", 64'(m_bc_msg_valid), 64'(0));
    rst_n = 1'b1;
    emit_msg.delete();
    repeat (10) step();
    check("t5_stale", 64'(emit_msg.size()), 64'(0));

    // Statistics after ten messages from core 1.
    for (int k = 0; k < 10; k++) tx_q[1].push_back(MW'(64'h8000 + 64'(k)));
    drain();
    stat_sel = IDW'(1);
    step();
    step();
`ifdef BC_MSG_STATS_EN
    stat_exp = 32'd10;
`else
    stat_exp = 32'd0;
`endif
    check("t6_stat", 64'(stat_count), 64'(stat_exp));

    // Random traffic with occasional flushes and resets.
    repeat (3000) begin
      for (int i = 0; i < int'(N); i++) begin
        gate[i] = ($urandom_range(0, 3) != 0);
        if (tx_q[i].size() < 3 && $urandom_range(0, 2) == 0)
          tx_q[i].push_back(MW'({$urandom, $urandom}));
        core_reset[i] = ($urandom_range(0, 63) == 0);
      end
      stat_sel = IDW'($urandom);
      rst_n    = ($urandom_range(0, 499) != 0);
      step();
    end
    core_reset = '0;
    rst_n      = 1'b1;
    for (int i = 0; i < int'(N); i++) gate[i] = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bc_msg_arbiter.md
# bc_msg_arbiter

Collects broadcast messages from every core's `bc_msg_out` channel and rebroadcasts them on a single shared bus. Each core's `bc_msg_in` port listens on that bus. Per-core messages are queued in small FIFOs and served round-robin, one message per cycle. The output bus has no backpressure, matching the core side, which accepts `bc_msg_in` unconditionally.

## Interface
Parameters:
- `CORE_COUNT`, 8: number of cores attached.
- `CORE_ID_WIDTH`, 3: width of a core index; must equal `$clog2(CORE_COUNT)`.
- `MSG_WIDTH`, 47: broadcast message width.
- `FIFO_DEPTH`, 4: per-core queue depth; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `core_reset`  in  `CORE_COUNT`  per-core flush, active-high.
- `s_bc_msg`  in  `CORE_COUNT*MSG_WIDTH`  per-core messages; core i occupies slice [i*MSG_WIDTH +: MSG_WIDTH].
- `s_bc_msg_valid`  in  `CORE_COUNT`  per-core valid.
- `s_bc_msg_ready`  out  `CORE_COUNT`  per-core ready.
- `m_bc_msg`  out  `MSG_WIDTH`  broadcast message.
- `m_bc_msg_valid`  out  1  broadcast valid, one-cycle pulse per message.
- `m_bc_msg_src`  out  `CORE_ID_WIDTH`  index of the originating core.
- `stat_sel`  in  `CORE_ID_WIDTH`  statistics counter select.
- `stat_count`  out  32  selected core's sent-message count.

## Operation
- Transfer on input i occurs when `s_bc_msg_valid[i] && s_bc_msg_ready[i]`; the message is pushed into FIFO i.
- `s_bc_msg_ready[i] = (count_i != FIFO_DEPTH) && !core_reset[i]`. The signal is combinational from registered state.
  - When the FIFO is full, a same-cycle pop does not re-enable push. Ready rises the next cycle.
- Arbiter each cycle:
  - Request vector is all FIFOs with `count != 0` and `core_reset` low.
  - Grant goes to the first requester at or after pointer `rr_ptr`, searching upward modulo `CORE_COUNT`.
  - The granted FIFO pops in the same cycle.
  - After a grant to core g, `rr_ptr` becomes (g+1) mod `CORE_COUNT`. With no grant, `rr_ptr` holds.
- Output register loads on a grant:
  - `m_bc_msg` takes the FIFO head.
  - `m_bc_msg_src` takes g.
  - `m_bc_msg_valid` is 1 the next cycle, else 0.
  - `m_bc_msg` and `m_bc_msg_src` hold their last values when valid is 0.
- `core_reset[i]` high:
  - FIFO i count and pointers are cleared that cycle.
  - Any push from core i is dropped.
  - FIFO i is excluded from arbitration.
  - A message from core i already in the output register is still emitted.
  - Other cores are unaffected.
- Reset `rst_n` = 0 sets these values:
  - all FIFOs empty;
  - `rr_ptr` = 0;
  - `m_bc_msg_valid` = 0, `m_bc_msg` = 0, `m_bc_msg_src` = 0;
  - `s_bc_msg_ready` = 0 during reset;
  - statistics counters = 0, `stat_count` = 0.
- Reset asserted mid-operation discards all queued and in-flight messages with no partial emission.

## Timing
- Uncontested latency: a message accepted at edge t is at the FIFO head after t. It is granted in cycle t+1 and appears with `m_bc_msg_valid` = 1 after edge t+2, i.e. 2 cycles.
- Aggregate throughput is one message per cycle. Per-core throughput is at least 1 message per `CORE_COUNT` cycles under full load.
- Fairness: under continuous load from every core, grants rotate 0,1,…,N-1 with no core skipped.
- `stat_count` is registered: it reflects `stat_sel` and the counter state from the previous cycle, i.e. one cycle of latency.

## Configuration
- Macro `BC_MSG_STATS_EN`.
- Defined:
  - One 32-bit counter per core, incremented on each grant to that core.
  - Counters wrap from 0xFFFFFFFF to 0.
  - Counters are cleared only by `rst_n`, not by `core_reset`.
- Undefined:
  - No counters are built.
  - `stat_count` is constant 0.
  - `stat_sel` is ignored.
  - Ports remain present.

## Structure
- Shared package `bc_msg_pkg`:
  - default constants for `MSG_WIDTH`, `CORE_ID_WIDTH`, `STAT_WIDTH` = 32;
  - a function for the round-robin next-pointer computation.
- Sub-module `bc_msg_fifo`, one instance per core:
  - parameterised by `MSG_WIDTH` and `FIFO_DEPTH`;
  - synchronous active-low reset plus a `flush` input;
  - exposes `count`, `head`, `push`, `pop`.
- The arbiter, output register and statistics live in the top module.

## Test plan
- Single message 0x1234 from core 3 into an idle block → `m_bc_msg_valid` = 1 two cycles after acceptance, `m_bc_msg` = 0x1234, `m_bc_msg_src` = 3, and one-cycle pulse only.
- All 8 cores present one message each in the same cycle, with `rr_ptr` = 0 → outputs arrive on 8 consecutive cycles in source order 0..7, and `rr_ptr` ends at 0.
- Core 5 streams 6 back-to-back messages while cores 0–4 each have a message queued → core 5's ready drops after 4 queued messages. All 11 messages are emitted with no loss or duplication, and round-robin order holds.
- Core 2 has 3 queued messages, then `core_reset[2]` is pulsed for 1 cycle → none of the remaining core 2 messages are emitted, other cores are unaffected, and core 2 accepts new messages after the pulse.
- `rst_n` is asserted while messages are queued and one is in the output register → `m_bc_msg_valid` = 0 the next cycle, no stale message appears after release, and `rr_ptr` = 0.
- With `BC_MSG_STATS_EN` defined, core 1 sends 10 messages and `stat_sel` = 1 → `stat_count` = 10. With the macro undefined, the same stimulus gives `stat_count` = 0.
